// File: rtl/sample_stream_reader.sv
// Streams a commanded run of samples from one bank of a synchronous sample memory to a
// 4-phase output handshake. Define SAMPLE_STREAM_LOOP_EN to add looping and early stop.
module sample_stream_reader #(
    parameter int DATA_W   = 8,
    parameter int BANK_W   = 4,
    parameter int LEN_LOG2 = 10
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       dav_,
    output logic                       rfd,
    input  logic [BANK_W-1:0]          enne,
    input  logic [LEN_LOG2-1:0]        len,
    output logic [BANK_W+LEN_LOG2-1:0] addr,
    input  logic [DATA_W-1:0]          d,
    output logic [DATA_W-1:0]          campione,
    output logic                       out_dav_,
    input  logic                       out_rfd,
`ifdef SAMPLE_STREAM_LOOP_EN
    input  logic                       loop,
    input  logic                       stop,
`endif
    output logic                       busy
);

    typedef enum logic [2:0] {IDLE, ACK, READ, LATCH, PRES, REL} state_t;

    localparam logic [LEN_LOG2:0]   CNT_ONE    = 1;
    localparam logic [LEN_LOG2-1:0] OFFSET_ONE = 1;

    state_t                state_q, state_d;
    logic [BANK_W-1:0]     bank_q, bank_d;
    logic [LEN_LOG2-1:0]   offset_q, offset_d;
    logic [LEN_LOG2:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]     campione_q, campione_d;
    logic                  rfd_q, rfd_d;
    logic                  out_dav_n_q, out_dav_n_d;
    logic                  busy_q, busy_d;
    logic [LEN_LOG2:0]     len_full;
`ifdef SAMPLE_STREAM_LOOP_EN
    logic                  loop_q, loop_d;
    logic                  stop_q, stop_d;
    logic [LEN_LOG2:0]     len_q, len_d;
`endif

    // A zero length encodes a full bank.
    assign len_full = (len == '0) ? {1'b1, {LEN_LOG2{1'b0}}} : {1'b0, len};

    always_comb begin
        state_d    = state_q;
        bank_d     = bank_q;
        offset_d   = offset_q;
        cnt_d      = cnt_q;
        campione_d = campione_q;
`ifdef SAMPLE_STREAM_LOOP_EN
        loop_d     = loop_q;
        len_d      = len_q;
        stop_d     = stop_q;
        if (state_q != IDLE && state_q != ACK && stop)
            stop_d = 1'b1;
`endif
        case (state_q)
            IDLE: begin
`ifdef SAMPLE_STREAM_LOOP_EN
                stop_d = 1'b0;
`endif
                // rfd_q gates acceptance so a command is only seen once rfd is visible.
                if (!dav_ && rfd_q) begin
                    bank_d   = enne;
                    offset_d = '0;
                    cnt_d    = len_full;
                    state_d  = ACK;
`ifdef SAMPLE_STREAM_LOOP_EN
                    loop_d   = loop;
                    len_d    = len_full;
`endif
                end
            end
            ACK:   if (dav_) state_d = READ;
            READ:  state_d = LATCH;
            LATCH: begin
                campione_d = d;
                state_d    = PRES;
            end
            PRES:  if (!out_rfd) state_d = REL;
            REL: begin
                if (out_rfd) begin
`ifdef SAMPLE_STREAM_LOOP_EN
                    if (stop_q || stop) begin
                        state_d = IDLE;
                    end else if (cnt_q == CNT_ONE) begin
                        if (loop_q) begin
                            cnt_d    = len_q;
                            offset_d = '0;
                            state_d  = READ;
                        end else begin
                            state_d  = IDLE;
                        end
                    end else begin
                        cnt_d    = cnt_q - CNT_ONE;
                        offset_d = offset_q + OFFSET_ONE;
                        state_d  = READ;
                    end
`else
                    if (cnt_q == CNT_ONE) begin
                        state_d  = IDLE;
                    end else begin
                        cnt_d    = cnt_q - CNT_ONE;
                        offset_d = offset_q + OFFSET_ONE;
                        state_d  = READ;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake outputs are registered from the next state, so they change with it.
        rfd_d       = (state_d == IDLE);
        out_dav_n_d = (state_d != PRES);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            bank_q      <= '0;
            offset_q    <= '0;
            cnt_q       <= '0;
            campione_q  <= '0;
            rfd_q       <= 1'b0;
            out_dav_n_q <= 1'b1;
            busy_q      <= 1'b0;
`ifdef SAMPLE_STREAM_LOOP_EN
            loop_q      <= 1'b0;
            stop_q      <= 1'b0;
            len_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            bank_q      <= bank_d;
            offset_q    <= offset_d;
            cnt_q       <= cnt_d;
            campione_q  <= campione_d;
            rfd_q       <= rfd_d;
            out_dav_n_q <= out_dav_n_d;
            busy_q      <= busy_d;
`ifdef SAMPLE_STREAM_LOOP_EN
            loop_q      <= loop_d;
            stop_q      <= stop_d;
            len_q       <= len_d;
`endif
        end
    end

    assign addr     = {bank_q, offset_q};
    assign rfd      = rfd_q;
    assign out_dav_ = out_dav_n_q;
    assign busy     = busy_q;
    assign campione = campione_q;

endmodule

// File: tb/tb_sample_stream_reader.sv
// Directed bench for sample_stream_reader: memory returns the low address byte, a negedge
// consumer process acknowledges samples and records what was presented.
module tb_sample_stream_reader;
    localparam int DATA_W   = 8;
    localparam int BANK_W   = 4;
    localparam int LEN_LOG2 = 10;
    localparam int ADDR_W   = BANK_W + LEN_LOG2;

    logic                clock = 1'b0;
    logic                reset;
    logic                dav_;
    logic                rfd;
    logic [BANK_W-1:0]   enne;
    logic [LEN_LOG2-1:0] len;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   d = '0;
    logic [DATA_W-1:0]   campione;
    logic                out_dav_;
    logic                out_rfd;
    logic                busy;
`ifdef SAMPLE_STREAM_LOOP_EN
    logic                loop;
    logic                stop;
`endif

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] sample_q[$];
    logic [ADDR_W-1:0] addr_q[$];
    int                hold_idx = 0;
    int                hold_left = 0;
    int                hold_cnt = 0;
    int                hold_bad = 0;
    int                rfd_busy_bad = 0;
    bit                zero_addr = 1'b0;
    logic              prev_dav = 1'b1;
    logic [DATA_W-1:0] hold_val = '0;

    sample_stream_reader #(
        .DATA_W(DATA_W), .BANK_W(BANK_W), .LEN_LOG2(LEN_LOG2)
    ) dut (
        .clock(clock), .reset(reset), .dav_(dav_), .rfd(rfd), .enne(enne), .len(len),
        .addr(addr), .d(d), .campione(campione), .out_dav_(out_dav_), .out_rfd(out_rfd),
`ifdef SAMPLE_STREAM_LOOP_EN
        .loop(loop), .stop(stop),
`endif
        .busy(busy)
    );

    always #5 clock = ~clock;

    // Synchronous memory: word is the low byte of the address, one clock of latency.
    always @(posedge clock) d <= addr[DATA_W-1:0];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Consumer: acknowledges each sample, optionally stalling one of them, and logs it.
    initial begin
        out_rfd = 1'b1;
        forever begin
            @(negedge clock);
            if (prev_dav && !out_dav_) begin
                sample_q.push_back(campione);
                addr_q.push_back(addr);
                hold_val = campione;
            end
            if (busy && addr == '0) zero_addr = 1'b1;
            if (busy && rfd) rfd_busy_bad++;
            if (!out_dav_ && out_rfd) begin
                if (sample_q.size() == hold_idx && hold_left > 0) begin
                    hold_left--;
                    hold_cnt++;
                    if (campione !== hold_val) hold_bad++;
                end else begin
                    out_rfd = 1'b0;
                end
            end else if (out_dav_ && !out_rfd) begin
                out_rfd = 1'b1;
            end
            prev_dav = out_dav_;
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic applyStimulus(input logic [BANK_W-1:0] bank, input logic [LEN_LOG2-1:0] length, input bit lp);
        for (int i = 0; i < 50 && !rfd; i++) tick();
        checkOutput("rfd_before_cmd", rfd, 1);
        sample_q.delete();
        addr_q.delete();
        enne = bank;
        len  = length;
`ifdef SAMPLE_STREAM_LOOP_EN
        loop = lp;
`else
        if (lp) $display("[TB] loop request ignored in single-pass build");
`endif
        dav_ = 1'b0;
        tick();
        checkOutput("busy_on_accept", busy, 1);
        checkOutput("rfd_on_accept", rfd, 0);
        dav_ = 1'b1;
    endtask

    task automatic waitIdle(input int budget);
        for (int n = 0; n < budget && busy; n++) tick();
        checkOutput("idle_timeout", busy, 0);
        checkOutput("rfd_after_done", rfd, 1);
    endtask

    task automatic waitSamples(input int count, input int budget);
        for (int n = 0; n < budget && sample_q.size() < count; n++) tick();
        checkOutput("sample_wait", (sample_q.size() >= count), 1);
    endtask

    task automatic checkRun(input string tag, input logic [ADDR_W-1:0] base, input int count);
        checkOutput({tag, "_count"}, sample_q.size(), count);
        for (int i = 0; i < sample_q.size() && i < count; i++) begin
            logic [ADDR_W-1:0] exp_addr;
            exp_addr = base + ADDR_W'(i);
            checkOutput({tag, "_addr"}, addr_q[i], exp_addr);
            checkOutput({tag, "_data"}, sample_q[i], exp_addr[DATA_W-1:0]);
        end
    endtask

    initial begin
        reset = 1'b1;
        dav_  = 1'b1;
        enne  = '0;
        len   = '0;
`ifdef SAMPLE_STREAM_LOOP_EN
        loop  = 1'b0;
        stop  = 1'b0;
`endif
        repeat (3) tick();
        checkOutput("rst_rfd", rfd, 0);
        checkOutput("rst_out_dav", out_dav_, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_campione", campione, 0);
        checkOutput("rst_addr", addr, 0);
        reset = 1'b0;
        tick();
        checkOutput("rfd_after_rst", rfd, 1);

        // Basic four-sample run from bank 3.
        applyStimulus(4'd3, 10'd4, 1'b0);
        waitIdle(200);
        checkRun("bank3", 14'hC00, 4);

        // Full-bank run from the top bank, must not wrap into bank 0.
        zero_addr = 1'b0;
        applyStimulus(4'd15, 10'd0, 1'b0);
        waitIdle(6000);
        checkRun("full", 14'h3C00, 1024);
        checkOutput("no_zero_addr", zero_addr, 0);

        // Consumer stalls the second sample for 10 cycles.
        hold_idx  = 2;
        hold_left = 10;
        hold_cnt  = 0;
        hold_bad  = 0;
        applyStimulus(4'd2, 10'd4, 1'b0);
        waitIdle(300);
        checkOutput("hold_cycles", hold_cnt, 10);
        checkOutput("hold_stable", hold_bad, 0);
        checkRun("hold", 14'h800, 4);
        hold_idx = 0;

        // A second command during playback is ignored.
        rfd_busy_bad = 0;
        applyStimulus(4'd1, 10'd8, 1'b0);
        waitSamples(3, 200);
        dav_ = 1'b0;
        enne = 4'd7;
        len  = 10'd2;
        repeat (3) tick();
        dav_ = 1'b1;
        waitIdle(300);
        checkRun("ignore", 14'h400, 8);
        checkOutput("rfd_low_while_busy", rfd_busy_bad, 0);

        // Reset in the middle of a 16-sample run.
        applyStimulus(4'd2, 10'd16, 1'b0);
        waitSamples(5, 200);
        reset = 1'b1;
        tick();
        checkOutput("midrst_out_dav", out_dav_, 1);
        checkOutput("midrst_rfd", rfd, 0);
        checkOutput("midrst_campione", campione, 0);
        checkOutput("midrst_busy", busy, 0);
        repeat (2) tick();
        reset = 1'b0;
        checkOutput("midrst_rfd_held", rfd, 0);
        tick();
        checkOutput("midrst_rfd_rise", rfd, 1);
        repeat (30) tick();
        checkOutput("midrst_no_more", sample_q.size(), 5);
        checkOutput("midrst_idle", busy, 0);

`ifdef SAMPLE_STREAM_LOOP_EN
        // Looping three-sample run, stopped during the second sample of pass three.
        applyStimulus(4'd5, 10'd3, 1'b1);
        waitSamples(8, 200);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        loop = 1'b0;
        waitIdle(200);
        checkOutput("loop_count", sample_q.size(), 8);
        for (int i = 0; i < sample_q.size() && i < 8; i++) begin
            logic [ADDR_W-1:0] exp_addr;
            exp_addr = 14'h1400 + ADDR_W'(i % 3);
            checkOutput("loop_addr", addr_q[i], exp_addr);
            checkOutput("loop_data", sample_q[i], exp_addr[DATA_W-1:0]);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
